// File: rtl/decode_regfile_pipe.sv
// rtl/decode_regfile_pipe.sv - Y86-64 decode stage: register file, source/dest selection, bypass, D->E pipeline registers
module decode_regfile_pipe #(
  parameter int                DATA_W   = 64,
  parameter int                NREGS    = 15,
  parameter int                RSP_IDX  = 4,
  parameter logic [DATA_W-1:0] RSP_INIT = '0,
  parameter bit                BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        d_icode,
  input  logic [3:0]        d_rA,
  input  logic [3:0]        d_rB,
  input  logic              d_stall,
  input  logic              d_bubble,
  input  logic [3:0]        w_dstE,
  input  logic [DATA_W-1:0] w_valE,
  input  logic [3:0]        w_dstM,
  input  logic [DATA_W-1:0] w_valM,
  input  logic [3:0]        dbg_idx,
  output logic [DATA_W-1:0] dbg_data,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic [3:0]        e_icode,
  output logic [DATA_W-1:0] e_valA,
  output logic [DATA_W-1:0] e_valB,
  output logic [3:0]        e_srcA,
  output logic [3:0]        e_srcB,
  output logic [3:0]        e_dstE,
  output logic [3:0]        e_dstM,
  output logic              e_valid
);

  localparam int         IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'(RSP_IDX);
  localparam logic [3:0] I_NOP = 4'h1;

  logic [DATA_W-1:0] regs_q [NREGS];

  logic [3:0]        dst_e, dst_m;
  logic [DATA_W-1:0] val_a, val_b;

  logic [3:0]        e_icode_q, e_icode_d;
  logic [DATA_W-1:0] e_vala_q, e_vala_d;
  logic [DATA_W-1:0] e_valb_q, e_valb_d;
  logic [3:0]        e_srca_q, e_srca_d;
  logic [3:0]        e_srcb_q, e_srcb_d;
  logic [3:0]        e_dste_q, e_dste_d;
  logic [3:0]        e_dstm_q, e_dstm_d;
  logic              e_valid_q, e_valid_d;

  // An index names a real register only if it is not RNONE and is implemented.
  function automatic logic in_range(input logic [3:0] idx);
    return (idx != RNONE) && (int'({28'd0, idx}) < NREGS);
  endfunction

  // Register/dest selection from the instruction code; unknown codes behave as NOP.
  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    dst_e  = RNONE;
    dst_m  = RNONE;
    case (d_icode)
      4'h2: begin d_srcA = d_rA; dst_e = d_rB; end
      4'h3: begin dst_e = d_rB; end
      4'h4: begin d_srcA = d_rA; d_srcB = d_rB; end
      4'h5: begin d_srcB = d_rB; dst_m = d_rA; end
      4'h6: begin d_srcA = d_rA; d_srcB = d_rB; dst_e = d_rB; end
      4'h8: begin d_srcB = RSP; dst_e = RSP; end
      4'h9: begin d_srcA = RSP; d_srcB = RSP; dst_e = RSP; end
      4'hA: begin d_srcA = d_rA; d_srcB = RSP; dst_e = RSP; end
      4'hB: begin d_srcA = RSP; d_srcB = RSP; dst_e = RSP; dst_m = d_rA; end
      default: ;
    endcase
  end

  // Operand reads; with BYPASS the in-flight writeback (M before E) overrides the array.
  always_comb begin
    val_a = '0;
    val_b = '0;
    if (in_range(d_srcA)) begin
      if (BYPASS && d_srcA == w_dstM)      val_a = w_valM;
      else if (BYPASS && d_srcA == w_dstE) val_a = w_valE;
      else                                 val_a = regs_q[d_srcA[IDX_W-1:0]];
    end
    if (in_range(d_srcB)) begin
      if (BYPASS && d_srcB == w_dstM)      val_b = w_valM;
      else if (BYPASS && d_srcB == w_dstE) val_b = w_valE;
      else                                 val_b = regs_q[d_srcB[IDX_W-1:0]];
    end
  end

  // Debug port shows raw array contents, no bypass.
  always_comb begin
    dbg_data = '0;
    if (in_range(dbg_idx)) dbg_data = regs_q[dbg_idx[IDX_W-1:0]];
  end

  // Register file: both writeback ports write each edge, M wins on a shared destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= (i == RSP_IDX) ? RSP_INIT : '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_dstM == 4'(i))      regs_q[i] <= w_valM;
        else if (w_dstE == 4'(i)) regs_q[i] <= w_valE;
      end
    end
  end

  // E-stage next state: bubble beats stall beats load.
  always_comb begin
    e_icode_d = e_icode_q;
    e_vala_d  = e_vala_q;
    e_valb_d  = e_valb_q;
    e_srca_d  = e_srca_q;
    e_srcb_d  = e_srcb_q;
    e_dste_d  = e_dste_q;
    e_dstm_d  = e_dstm_q;
    e_valid_d = e_valid_q;
    if (d_bubble) begin
      e_icode_d = I_NOP;
      e_vala_d  = '0;
      e_valb_d  = '0;
      e_srca_d  = RNONE;
      e_srcb_d  = RNONE;
      e_dste_d  = RNONE;
      e_dstm_d  = RNONE;
      e_valid_d = 1'b0;
    end else if (!d_stall) begin
      e_icode_d = d_icode;
      e_vala_d  = val_a;
      e_valb_d  = val_b;
      e_srca_d  = d_srcA;
      e_srcb_d  = d_srcB;
      e_dste_d  = dst_e;
      e_dstm_d  = dst_m;
      e_valid_d = 1'b1;
    end
  end

  // E-stage registers reset to a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_icode_q <= I_NOP;
      e_vala_q  <= '0;
      e_valb_q  <= '0;
      e_srca_q  <= RNONE;
      e_srcb_q  <= RNONE;
      e_dste_q  <= RNONE;
      e_dstm_q  <= RNONE;
      e_valid_q <= 1'b0;
    end else begin
      e_icode_q <= e_icode_d;
      e_vala_q  <= e_vala_d;
      e_valb_q  <= e_valb_d;
      e_srca_q  <= e_srca_d;
      e_srcb_q  <= e_srcb_d;
      e_dste_q  <= e_dste_d;
      e_dstm_q  <= e_dstm_d;
      e_valid_q <= e_valid_d;
    end
  end

  assign e_icode = e_icode_q;
  assign e_valA  = e_vala_q;
  assign e_valB  = e_valb_q;
  assign e_srcA  = e_srca_q;
  assign e_srcB  = e_srcb_q;
  assign e_dstE  = e_dste_q;
  assign e_dstM  = e_dstm_q;
  assign e_valid = e_valid_q;

endmodule
